// File: rtl/mux_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux_arb_pkg : shared types, reset values and arbitration helper for mux_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    SWITCH  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  localparam int         c_dead_cnt_w = 4;
  localparam arb_state_t c_rst_state  = IDLE;
  localparam side_t      c_rst_last   = SIDE_B;
  localparam logic       c_rst_sel    = 1'b1;
  localparam logic       c_rst_out    = 1'b0;

  // On a tie the side that did not own the mux last time wins.
  function automatic arb_state_t arbitrate(input logic ra, input logic rb, input side_t last);
    arb_state_t res;
    res = IDLE;
    if (ra && rb) begin
      res = (last == SIDE_B) ? GRANT_A : GRANT_B;
    end else if (ra) begin
      res = GRANT_A;
    end else if (rb) begin
      res = GRANT_B;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_arb_timer.sv
// ----------------------------------------------------------------------------
// mux_arb_timer : loadable saturating down-counter with a zero flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_arb_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ----------------------------------------------------------------------------
// mux_arbiter : two-requester round-robin owner of a 2:1 mux, registered output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter int DEAD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic a,
  input  logic b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic out,
  output logic busy
);

  localparam int                 HOLD_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]  c_hold_load = HOLD_W'(MAX_HOLD - 1);
  localparam logic [c_dead_cnt_w-1:0] c_dead_load = c_dead_cnt_w'(DEAD_CYCLES - 1);

  arb_state_t r_state;
  arb_state_t w_next;
  arb_state_t w_arb;
  side_t      r_last;
  logic       r_sel;
  logic       r_out;

  logic w_hold_done;
  logic w_hold_load;
  logic w_hold_dec;
  logic w_dead_done;
  logic w_dead_load;
  logic w_dead_dec;
  logic w_enter_a;
  logic w_enter_b;

  assign w_arb = arbitrate(req_a, req_b, r_last);

  // Hold timer counts the remaining contended cycles; preempt fires once it reaches zero.
  always_comb begin
    w_next     = r_state;
    w_hold_dec = 1'b0;
    w_dead_dec = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = w_arb;
      end
      GRANT_A: begin
        if (!req_a || (req_b && w_hold_done)) begin
          w_next = SWITCH;
        end else begin
          w_hold_dec = req_b;
        end
      end
      GRANT_B: begin
        if (!req_b || (req_a && w_hold_done)) begin
          w_next = SWITCH;
        end else begin
          w_hold_dec = req_a;
        end
      end
      SWITCH: begin
        if (w_dead_done) begin
          w_next = w_arb;
        end else begin
          w_dead_dec = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_enter_a   = (w_next == GRANT_A) && (r_state != GRANT_A);
  assign w_enter_b   = (w_next == GRANT_B) && (r_state != GRANT_B);
  assign w_hold_load = w_enter_a || w_enter_b;
  assign w_dead_load = (w_next == SWITCH) && (r_state != SWITCH);

  mux_arb_timer #(
    .WIDTH (HOLD_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_hold_load),
    .i_load_val (c_hold_load),
    .i_dec      (w_hold_dec),
    .o_done     (w_hold_done)
  );

  mux_arb_timer #(
    .WIDTH (c_dead_cnt_w)
  ) u_dead_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dead_load),
    .i_load_val (c_dead_load),
    .i_dec      (w_dead_dec),
    .o_done     (w_dead_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_rst_state;
      r_last  <= c_rst_last;
      r_sel   <= c_rst_sel;
      r_out   <= c_rst_out;
    end else begin
      r_state <= w_next;
      if (w_enter_a) begin
        r_last <= SIDE_A;
        r_sel  <= 1'b1;
      end else if (w_enter_b) begin
        r_last <= SIDE_B;
        r_sel  <= 1'b0;
      end
      if (gnt_a) begin
        r_out <= a;
      end else if (gnt_b) begin
        r_out <= b;
      end else begin
        r_out <= 1'b0;
      end
    end
  end

  assign gnt_a = (r_state == GRANT_A);
  assign gnt_b = (r_state == GRANT_B);
  assign busy  = (r_state != IDLE);
  assign sel   = r_sel;
  assign out   = r_out;

endmodule

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_arbiter : scoreboard bench for mux_arbiter (MAX_HOLD=4, DEAD_CYCLES 1 and 2)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req_a, req_b, a, b;
  logic gnt_a1, gnt_b1, sel1, out1, busy1;
  logic gnt_a2, gnt_b2, sel2, out2, busy2;
  logic [4:0] w_obs1;
  logic [4:0] w_obs2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  mux_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .out(out1), .busy(busy1)
  );

  mux_arbiter #(.MAX_HOLD(4), .DEAD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a2), .gnt_b(gnt_b2), .sel(sel2), .out(out2), .busy(busy2)
  );

  // Observed vector order: {gnt_a, gnt_b, sel, out, busy}
  assign w_obs1 = {gnt_a1, gnt_b1, sel1, out1, busy1};
  assign w_obs2 = {gnt_a2, gnt_b2, sel2, out2, busy2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    {req_a, req_b, a, b} = 4'b0000;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      {req_a, req_b, a, b} = 4'($urandom_range(0, 15));
      exp_q.push_back(5'b00100);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (w_obs1 !== e) begin
        n_fail++;
        $display("FAIL reset_d1 cyc %0d: got %b want %b", k, w_obs1, e);
      end
      n_tests++;
      if (w_obs2 !== e) begin
        n_fail++;
        $display("FAIL reset_d2 cyc %0d: got %b want %b", k, w_obs2, e);
      end
    end
    {req_a, req_b, a, b} = 4'b0000;
    rst = 1'b0;
    exp_q.push_back(5'b00100);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (w_obs1 !== e) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", w_obs1, e);
    end
  endtask

  task automatic test_single_a();
    logic [3:0] stim [6];
    logic [4:0] expv [6];
    logic [4:0] e;
    stim = '{4'b1010, 4'b1011, 4'b1001, 4'b1010, 4'b0001, 4'b0001};
    expv = '{5'b10101, 5'b10111, 5'b10101, 5'b10111, 5'b00101, 5'b00100};
    for (int k = 0; k < 6; k++) begin
      {req_a, req_b, a, b} = stim[k];
      exp_q.push_back(expv[k]);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (w_obs1 !== e) begin
        n_fail++;
        $display("FAIL single_a cyc %0d: got %b want %b", k, w_obs1, e);
      end
    end
    settle();
  endtask

  task automatic test_tie();
    logic [3:0] stim [7];
    logic [4:0] expv [7];
    logic [4:0] e;
    {req_a, req_b, a, b} = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stim = '{4'b1111, 4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b0011, 4'b0011};
    expv = '{5'b10101, 5'b10111, 5'b00111, 5'b01001, 5'b01011, 5'b00011, 5'b00000};
    for (int k = 0; k < 7; k++) begin
      {req_a, req_b, a, b} = stim[k];
      exp_q.push_back(expv[k]);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (w_obs1 !== e) begin
        n_fail++;
        $display("FAIL tie cyc %0d: got %b want %b", k, w_obs1, e);
      end
    end
    settle();
  endtask

  task automatic test_contention();
    logic [4:0] plan[$];
    logic [4:0] e;
    for (int r = 0; r < 3; r++) begin
      plan.push_back(5'b10101);
      for (int j = 0; j < 3; j++) plan.push_back(5'b10111);
      plan.push_back(5'b00111);
      plan.push_back(5'b01001);
      for (int j = 0; j < 3; j++) plan.push_back(5'b01011);
      plan.push_back(5'b00011);
    end
    plan.push_back(5'b10101);
    plan.push_back(5'b00111);
    plan.push_back(5'b00100);
    for (int k = 0; k < plan.size(); k++) begin
      {req_a, req_b, a, b} = (k < 31) ? 4'b1111 : 4'b0011;
      exp_q.push_back(plan[k]);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (w_obs1 !== e) begin
        n_fail++;
        $display("FAIL contention cyc %0d: got %b want %b", k, w_obs1, e);
      end
    end
    settle();
  endtask

  task automatic test_release();
    logic [3:0] stim [6];
    logic [4:0] expv [6];
    logic [4:0] e;
    stim = '{4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0001};
    expv = '{5'b01001, 5'b01011, 5'b01011, 5'b00011, 5'b00001, 5'b00000};
    for (int k = 0; k < 6; k++) begin
      {req_a, req_b, a, b} = stim[k];
      exp_q.push_back(expv[k]);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (w_obs2 !== e) begin
        n_fail++;
        $display("FAIL release cyc %0d: got %b want %b", k, w_obs2, e);
      end
    end
    settle();
  endtask

  task automatic test_async_reset();
    logic [4:0] e;
    {req_a, req_b, a, b} = 4'b0101;
    exp_q.push_back(5'b01001);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (w_obs1 !== e) begin
      n_fail++;
      $display("FAIL async_pre0: got %b want %b", w_obs1, e);
    end
    exp_q.push_back(5'b01011);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (w_obs1 !== e) begin
      n_fail++;
      $display("FAIL async_pre1: got %b want %b", w_obs1, e);
    end
    #3;
    rst = 1'b1;
    exp_q.push_back(5'b00100);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (w_obs1 !== e) begin
      n_fail++;
      $display("FAIL async_now_d1: got %b want %b", w_obs1, e);
    end
    n_tests++;
    if (w_obs2 !== e) begin
      n_fail++;
      $display("FAIL async_now_d2: got %b want %b", w_obs2, e);
    end
    tick();
    {req_a, req_b, a, b} = 4'b1111;
    #2;
    rst = 1'b0;
    exp_q.push_back(5'b10101);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (w_obs1 !== e) begin
      n_fail++;
      $display("FAIL async_after_d1: got %b want %b", w_obs1, e);
    end
    n_tests++;
    if (w_obs2 !== e) begin
      n_fail++;
      $display("FAIL async_after_d2: got %b want %b", w_obs2, e);
    end
    settle();
  endtask

  initial begin
    rst = 1'b1;
    {req_a, req_b, a, b} = 4'b0000;
    test_reset();
    test_single_a();
    test_tie();
    test_contention();
    test_release();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that owns the select line of the 2:1 mux on the ice40 stick and registers the muxed output. Requesters A and B raise a request; the arbiter grants one at a time, bounds how long a holder may keep the mux under contention, and inserts dead cycles between owners so `out` never glitches from one source straight to the other. It sits between the board-level request sources and the mux datapath.

## Interface
Parameters:
- `MAX_HOLD`, default 8: cycles a holder keeps the grant while the other side is requesting. Legal range 1..255.
- `DEAD_CYCLES`, default 1: idle cycles inserted on every grant release. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_a`, `req_b`  in  1  level requests; a request is held until it is served or abandoned.
- `a`, `b`  in  1  data inputs to the mux.
- `gnt_a`, `gnt_b`  out  1  one-hot-or-zero grants, decoded from state (Moore outputs).
- `sel`  out  1  mux select; 1 selects `a`, 0 selects `b`.
- `out`  out  1  registered mux output.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, GRANT_A, GRANT_B, SWITCH.
- Reset values: state IDLE; `gnt_a`=`gnt_b`=0; `sel`=1; `out`=0; `busy`=0; `last`=B, so A wins the first tie; hold and dead counters 0.
- IDLE or end of SWITCH, arbitration:
  - Only one request high: grant it.
  - Both high: grant the side not equal to `last`.
  - Neither high: go to (or stay in) IDLE.
- Entering GRANT_x: `last`<=x, `hold_cnt`<=0, `sel`<=(x==A).
- In GRANT_x, at each edge:
  - req_x low: go to SWITCH (release).
  - Else, other request high and `hold_cnt`==MAX_HOLD-1: go to SWITCH (preempt).
  - Else, other request high: `hold_cnt`++.
  - Else: `hold_cnt` holds its value. It does not reset when contention stops.
- Release and preempt at the same edge give the same result: one transition to SWITCH.
- SWITCH lasts exactly DEAD_CYCLES cycles (`dead_cnt` counts down from DEAD_CYCLES-1). Both grants are low. `sel` holds its last value. Requests are ignored until the final SWITCH cycle's edge, when arbitration runs as above.
- `out` register, updated each edge:
  - `gnt_a` high: `out`<=`a`.
  - `gnt_b` high: `out`<=`b`.
  - Otherwise: `out`<=0.
- Counter widths: `hold_cnt` $clog2(MAX_HOLD+1), `dead_cnt` 4 bits. Neither counter wraps; both saturate by construction.

## Timing
- Request sampled at edge n gives grant high in cycle n..n+1 (one-cycle grant latency from IDLE).
- Data on `a`/`b` during a grant cycle appears on `out` after the next edge (one-cycle data latency).
- Gap between consecutive owners is DEAD_CYCLES cycles with both grants low. `out` is 0 from the second of those cycles.
- Under continuous contention, each side holds for exactly MAX_HOLD cycles, then the dead gap follows.
- `rst` asserted mid-grant: all outputs take their reset values immediately, without waiting for `clk`. On deassertion, arbitration restarts from IDLE with A preferred.

## Structure
- Package `mux_arb_pkg` contains:
  - `arb_state_t` enum (IDLE, GRANT_A, GRANT_B, SWITCH).
  - `side_t` (A, B) for `last`.
  - Reset constants.
- One sub-module, `mux_arb_timer`: a parameterised loadable down-counter with a `done` flag, instantiated twice (hold and dead). The FSM, grant decode and `out` register stay in `mux_arbiter`.

## Test plan
- Reset: `rst`=1 with random inputs. Expect `gnt_a`=`gnt_b`=0, `sel`=1, `out`=0, `busy`=0 throughout reset.
- Single A: `req_a` rises before edge 2 with `a`=1. Expect `gnt_a`=1 from cycle 2 and `out`=1 after edge 3. `b` toggling never reaches `out`.
- Tie from reset: `req_a`=`req_b`=1 at the same edge. Expect A granted first. After A drops `req_a`, expect the DEAD_CYCLES gap, then `gnt_b`=1 and `sel`=0.
- Contention, MAX_HOLD=4, DEAD_CYCLES=1, both requests held high. Expect the sequence: A for 4 cycles, 1 dead cycle, B for 4 cycles, 1 dead cycle, A. Repeat for 3 rounds.
- Release with no waiter: `req_b` alone, held 3 cycles then dropped, DEAD_CYCLES=2. Expect `gnt_b` high for 3 cycles, then SWITCH for 2 cycles with `out`=0, then IDLE with `busy`=0.
- Async reset mid-grant: assert `rst` between clock edges during GRANT_B. Expect outputs at reset values before the next edge. After release with both requests high, expect A granted first.
